// File: rtl/back_propagation_sequencer_pkg.sv
// Shared types for the back-propagation stage sequencer: FSM state encoding
// and the index-width helper used for stage index ports.
package back_propagation_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_GAP,
      ST_FINISH,
      ST_ERROR
   } state_t;

   // A single-stage chain still needs a 1-bit index port.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/back_propagation_sequencer_watchdog.sv
// Clear/enable cycle counter with an expired flag; serves as both the per-stage
// timeout and the inter-stage settle-gap counter.
module bp_seq_watchdog #(
   parameter int LIMIT = 16,
   parameter int WIDTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [WIDTH-1:0] LAST = (LIMIT > 0) ? WIDTH'(LIMIT - 1) : '0;

   logic [WIDTH-1:0] count;

   // Expired marks the LIMIT-th enabled cycle; the count parks there until cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && !expired)
         count <= count + WIDTH'(1);
   end

   assign expired = (LIMIT > 0) && (count == LAST);

endmodule

// File: rtl/back_propagation_sequencer.sv
// Sequences one back-propagation pass: output-layer delta, hidden layers, then
// weight update, with a settle gap between stages, per-stage watchdog and abort.
module back_propagation_sequencer
   import back_propagation_sequencer_pkg::*;
#(
   parameter int NUM_STAGES     = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_start,
   input  logic                                 i_abort,
   input  logic [NUM_STAGES-1:0]                i_stage_done,
   output logic [NUM_STAGES-1:0]                o_stage_start,
   output logic [idx_width(NUM_STAGES)-1:0]     o_stage_idx,
   output logic                                 o_busy,
   output logic                                 o_done,
   output logic                                 o_error,
   output logic [idx_width(NUM_STAGES)-1:0]     o_err_stage,
   output logic [CNT_WIDTH-1:0]                 o_pass_count
);

   localparam int IDX_W = idx_width(NUM_STAGES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

   state_t           state;
   logic             wd_expired;
   logic             gap_expired;
   logic             stage_done;
   logic             last_stage;
   logic [IDX_W-1:0] next_idx;

   function automatic logic [NUM_STAGES-1:0] onehot(input logic [IDX_W-1:0] i);
      logic [NUM_STAGES-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Only the active stage's done bit is honoured; other layers' pulses are ignored.
   assign stage_done = i_stage_done[o_stage_idx];
   assign last_stage = (o_stage_idx == LAST_IDX);
   assign next_idx   = o_stage_idx + IDX_W'(1);

   bp_seq_watchdog #(.LIMIT(TIMEOUT_CYCLES), .WIDTH(CNT_WIDTH)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == ST_LAUNCH),
      .enable  (state == ST_WAIT),
      .expired (wd_expired)
   );

   bp_seq_watchdog #(.LIMIT(GAP_CYCLES), .WIDTH(CNT_WIDTH)) u_gap (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == ST_WAIT),
      .enable  (state == ST_GAP),
      .expired (gap_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         o_stage_start <= '0;
         o_stage_idx   <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_error       <= 1'b0;
         o_err_stage   <= '0;
         o_pass_count  <= '0;
      end else begin
         o_stage_start <= '0;
         o_done        <= 1'b0;
         o_error       <= 1'b0;
         // Abort outranks start, done and timeout; in IDLE it just blocks a start.
         if (i_abort) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (i_start) begin
                     state         <= ST_LAUNCH;
                     o_busy        <= 1'b1;
                     o_stage_idx   <= '0;
                     o_stage_start <= onehot('0);
                  end
               end
               ST_LAUNCH: state <= ST_WAIT;
               ST_WAIT: begin
                  // A done in the expiry cycle still wins over the watchdog.
                  if (stage_done) begin
                     if (last_stage) begin
                        state        <= ST_FINISH;
                        o_done       <= 1'b1;
                        o_pass_count <= o_pass_count + CNT_WIDTH'(1);
                     end else if (GAP_CYCLES == 0) begin
                        state         <= ST_LAUNCH;
                        o_stage_idx   <= next_idx;
                        o_stage_start <= onehot(next_idx);
                     end else begin
                        state <= ST_GAP;
                     end
                  end else if (wd_expired) begin
                     state       <= ST_ERROR;
                     o_error     <= 1'b1;
                     o_err_stage <= o_stage_idx;
                  end
               end
               ST_GAP: begin
                  if (gap_expired) begin
                     state         <= ST_LAUNCH;
                     o_stage_idx   <= next_idx;
                     o_stage_start <= onehot(next_idx);
                  end
               end
               ST_FINISH, ST_ERROR: begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
               end
               default: begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_back_propagation_sequencer.sv
// Randomized bench for the back-propagation sequencer against a schedule model
// derived from per-stage layer latencies.
module tb_back_propagation_sequencer;

   localparam int N  = 4;
   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        sel = 1'b0;
   logic [3:0]  sdone = '0;

   logic [3:0]  st_a, st_b, st;
   logic [1:0]  idx_a, idx_b, idx, es_a, es_b, es;
   logic        busy_a, busy_b, busy, done_a, done_b, done, err_a, err_b, err;
   logic [15:0] pc_a, pc_b, pc;

   assign st   = sel ? st_b   : st_a;
   assign idx  = sel ? idx_b  : idx_a;
   assign es   = sel ? es_b   : es_a;
   assign busy = sel ? busy_b : busy_a;
   assign done = sel ? done_b : done_a;
   assign err  = sel ? err_b  : err_a;
   assign pc   = sel ? pc_b   : pc_a;

   back_propagation_sequencer #(.NUM_STAGES(N), .GAP_CYCLES(2), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut_a (
      .clk(clk), .rst(rst), .i_start(start & ~sel), .i_abort(abort & ~sel),
      .i_stage_done(sel ? 4'b0 : sdone), .o_stage_start(st_a), .o_stage_idx(idx_a),
      .o_busy(busy_a), .o_done(done_a), .o_error(err_a), .o_err_stage(es_a), .o_pass_count(pc_a));

   back_propagation_sequencer #(.NUM_STAGES(N), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut_b (
      .clk(clk), .rst(rst), .i_start(start & sel), .i_abort(abort & sel),
      .i_stage_done(sel ? sdone : 4'b0), .o_stage_start(st_b), .o_stage_idx(idx_b),
      .o_busy(busy_b), .o_done(done_b), .o_error(err_b), .o_err_stage(es_b), .o_pass_count(pc_b));

   always #5 clk = ~clk;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   // Reference schedule, indexed by cycle offset from the cycle i_start is driven.
   logic [3:0] e_start [0:255];
   bit         e_busy  [0:255];
   bit         e_done  [0:255];
   bit         e_err   [0:255];
   int         lat     [0:3];
   int         done_at [0:3];
   int         end_c, last_k, err_k, seen_done;
   bit         ok, errd;
   int         exp_pc [0:1];
   int         exp_es [0:1];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Stage k starts one cycle after the previous done plus the gap; a latency of 0
   // (never answers) or beyond TO leaves an error TO+1 cycles after that start.
   task automatic model_fill(input int gap);
      int s, d;
      for (int r = 0; r < 256; r++) begin
         e_start[r] = '0; e_busy[r] = 0; e_done[r] = 0; e_err[r] = 0;
      end
      for (int k = 0; k < N; k++) done_at[k] = -1;
      ok = 0; errd = 0; s = 1;
      for (int k = 0; k < N; k++) begin
         e_start[s] = 4'(1 << k);
         last_k = k;
         if (lat[k] == 0 || lat[k] > TO) begin
            errd = 1; err_k = k; end_c = s + TO + 1; e_err[end_c] = 1;
            break;
         end
         d = s + lat[k];
         done_at[k] = d;
         if (k == N - 1) begin
            ok = 1; end_c = d + 1; e_done[end_c] = 1;
         end else begin
            s = d + gap + 1;
         end
      end
      for (int r = 1; r <= end_c; r++) e_busy[r] = 1;
   endtask

   // Abort driven in cycle a: everything after a disappears.
   task automatic model_abort(input int a);
      for (int r = a + 1; r < 256; r++) begin
         e_start[r] = '0; e_busy[r] = 0; e_done[r] = 0; e_err[r] = 0;
      end
      if (end_c > a) begin
         ok = 0; errd = 0; end_c = a;
      end
   endtask

   task automatic run_pass(input int gap, input int abort_at, input bit noise);
      int a;
      model_fill(gap);
      a = (abort_at < 0) ? $urandom_range(1, end_c) : abort_at;
      if (a > 0) model_abort(a);
      seen_done = -1;
      for (int r = 0; r <= end_c + 2; r++) begin
         start = (r == 0) || (noise && r == 3);
         abort = (a > 0) && (r == a);
         for (int k = 0; k < N; k++) sdone[k] = (done_at[k] == r);
         if (noise && r == 2) sdone[3] = 1'b1;
         tick();
         start = 1'b0; abort = 1'b0; sdone = '0;
         if (done && seen_done < 0) seen_done = cyc;
         check_val("stage_start", st, e_start[r+1]);
         check_val("busy", busy, e_busy[r+1]);
         check_val("done", done, e_done[r+1]);
         check_val("error", err, e_err[r+1]);
      end
      if (ok) exp_pc[sel] = exp_pc[sel] + 1;
      if (errd) exp_es[sel] = err_k;
      check_val("pass_count", pc, exp_pc[sel]);
      check_val("err_stage", es, exp_es[sel]);
      if (a == 0) check_val("idle_stage_idx", idx, last_k);
   endtask

   task automatic random_lat();
      for (int k = 0; k < N; k++)
         lat[k] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 21);
   endtask

   initial begin
      exp_pc[0] = 0; exp_pc[1] = 0; exp_es[0] = 0; exp_es[1] = 0;
      tick(); tick();
      check_val("rst_start", st, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_idx", idx, 0);
      check_val("rst_pass", pc, 0);
      rst = 1'b0;
      cyc = 0;
      while (cyc < 10) tick();

      // Every layer answers 5 cycles after its start.
      lat = '{5, 5, 5, 5};
      run_pass(2, 0, 0);
      check_val("t1_done_cycle", seen_done, 41);

      // Stage 2 never answers.
      lat = '{5, 5, 0, 5};
      run_pass(2, 0, 0);

      // Stage 0 start 1, done 4, stage 1 start 7, done 10; cycle 11 is in its gap.
      lat = '{3, 3, 5, 5};
      run_pass(2, 11, 0);

      // Stray done of stage 3 and a start while busy.
      lat = '{4, 6, 3, 5};
      run_pass(2, 0, 1);

      // Reset while stage 1 is waiting.
      start = 1'b1; tick(); start = 1'b0;
      tick();
      sdone = 4'b0001; tick(); sdone = '0;
      tick(); tick();
      check_val("t6_stage1_start", st, 4'b0010);
      tick();
      rst = 1'b1;
      #1;
      check_val("t6_rst_busy", busy, 0);
      check_val("t6_rst_start", st, 0);
      check_val("t6_rst_idx", idx, 0);
      check_val("t6_rst_pass", pc, 0);
      check_val("t6_rst_err_stage", es, 0);
      tick();
      rst = 1'b0;
      exp_pc[0] = 0; exp_pc[1] = 0; exp_es[0] = 0; exp_es[1] = 0;
      lat = '{2, 2, 2, 2};
      run_pass(2, 0, 0);

      for (int i = 0; i < 10; i++) begin
         int mode;
         random_lat();
         mode = $urandom_range(0, 3);
         run_pass(2, (mode == 0) ? -1 : 0, mode == 1);
      end

      // Zero-gap instance: immediate dones, and a done exactly at the timeout.
      sel = 1'b1;
      tick();
      lat = '{1, 1, TO, 1};
      run_pass(0, 0, 0);
      lat = '{2, TO + 1, 3, 3};
      run_pass(0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         int mode;
         random_lat();
         mode = $urandom_range(0, 3);
         run_pass(0, (mode == 0) ? -1 : 0, mode == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got cycle %0d required finish", cyc);
      $fatal(1);
   end

endmodule
